// File: rtl/partition_exhaustive_checker.sv
// Exhaustive-sweep checker: drives every input pattern into an exact and an approximate
// copy of a partition, then accumulates mismatch, bit-flip and absolute-error metrics.
module partition_exhaustive_checker #(
    parameter int IN_W    = 7,
    parameter int OUT_W   = 4,
    parameter int DUT_LAT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [IN_W-1:0]                  pi,
    input  logic [OUT_W-1:0]                 exact_po,
    input  logic [OUT_W-1:0]                 approx_po,
    output logic                             busy,
    output logic                             done,
    output logic [IN_W:0]                    mismatch_cnt,
    output logic [IN_W+$clog2(OUT_W+1)-1:0]  bitflip_cnt,
    output logic [OUT_W-1:0]                 max_abs_err,
    output logic [IN_W+OUT_W-1:0]            sum_abs_err
);

    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int MC_W  = IN_W + 1;
    localparam int BF_W  = IN_W + PC_W;
    localparam int SE_W  = IN_W + OUT_W;
    localparam int CNT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic             tag;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] abs_err;
    logic [PC_W-1:0]  flips;

    always_comb begin
        diff    = exact_po ^ approx_po;
        abs_err = (exact_po >= approx_po) ? exact_po - approx_po : approx_po - exact_po;
        flips   = '0;
        for (int i = 0; i < OUT_W; i++) begin
            flips = flips + PC_W'(diff[i]);
        end
    end

    // The tag marks the cycle in which the DUT outputs belong to a presented pattern.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign tag = (state == SWEEP);
        end else begin : g_pipe
            logic [DUT_LAT-1:0] tag_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_sr <= '0;
                end else begin
                    tag_sr <= (tag_sr << 1) | DUT_LAT'(state == SWEEP);
                end
            end
            assign tag = tag_sr[DUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pi           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            drain_cnt    <= '0;
            mismatch_cnt <= '0;
            bitflip_cnt  <= '0;
            max_abs_err  <= '0;
            sum_abs_err  <= '0;
        end else begin
            done <= 1'b0;
            if (tag) begin
                mismatch_cnt <= mismatch_cnt + MC_W'(diff != '0);
                bitflip_cnt  <= bitflip_cnt + BF_W'(flips);
                sum_abs_err  <= sum_abs_err + SE_W'(abs_err);
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                end
            end
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state        <= SWEEP;
                        pi           <= '0;
                        busy         <= 1'b1;
                        mismatch_cnt <= '0;
                        bitflip_cnt  <= '0;
                        max_abs_err  <= '0;
                        sum_abs_err  <= '0;
                    end
                end
                SWEEP: begin
                    if (pi == '1) begin
                        if (DUT_LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LAST;
                        end else begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        pi <= pi + IN_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_partition_exhaustive_checker.sv
// Directed bench: a combinational checker and a two-stage pipelined checker sweep the
// same functions side by side; timing and metrics are compared to hand-computed values.
module tb_partition_exhaustive_checker;

    localparam int IN_W  = 7;
    localparam int OUT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;

    logic [IN_W-1:0]  pi0, pi2;
    logic [OUT_W-1:0] exact0, approx0, s1e, s1a, s2e, s2a;
    logic             busy0, done0, busy2, done2;
    logic [IN_W:0]    mis0, mis2;
    logic [IN_W+2:0]  bf0, bf2;
    logic [OUT_W-1:0] max0, max2;
    logic [IN_W+OUT_W-1:0] sum0, sum2;

    int testsRun = 0;
    int failCount = 0;
    int doneCyc0, doneCyc2, doneCnt0, doneCnt2, busyErr0, busyErr2;
    int piFirst0, piLast0, piHold2;
    int r0 [4];
    int r2 [4];
    int rs [8];

    always #5 clk = ~clk;

    function automatic logic [3:0] approxOf(input logic [1:0] m, input logic [3:0] e);
        case (m)
            2'd1:    approxOf = e ^ 4'b0001;
            2'd2:    approxOf = 4'b0000;
            default: approxOf = e;
        endcase
    endfunction

    assign exact0  = pi0[3:0];
    assign approx0 = approxOf(mode, pi0[3:0]);

    // Both copies of the latency-2 partition are wrapped in two register stages.
    always @(posedge clk) begin
        s1e <= pi2[3:0];
        s1a <= approxOf(mode, pi2[3:0]);
        s2e <= s1e;
        s2a <= s1a;
    end

    partition_exhaustive_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pi(pi0),
        .exact_po(exact0), .approx_po(approx0), .busy(busy0), .done(done0),
        .mismatch_cnt(mis0), .bitflip_cnt(bf0), .max_abs_err(max0), .sum_abs_err(sum0)
    );

    partition_exhaustive_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pi(pi2),
        .exact_po(s2e), .approx_po(s2a), .busy(busy2), .done(done2),
        .mismatch_cnt(mis2), .bitflip_cnt(bf2), .max_abs_err(max2), .sum_abs_err(sum2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Cycle n of the loop is cycle k+n, where start is sampled at edge k.
    task automatic applyStimulus(input int startPulseAt, input int resetAt, input int nCycles);
        doneCyc0 = 0; doneCyc2 = 0; doneCnt0 = 0; doneCnt2 = 0; busyErr0 = 0; busyErr2 = 0;
        for (int i = 0; i < 4; i++) begin
            r0[i] = -1;
            r2[i] = -1;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= nCycles; n++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (n == 1)   piFirst0 = int'(pi0);
            if (n == 128) piLast0  = int'(pi0);
            if (n == 130) piHold2  = int'(pi2);
            if (busy0 !== (n <= 128)) busyErr0++;
            if (busy2 !== (n <= 130)) busyErr2++;
            if (done0 === 1'b1) begin
                doneCnt0++;
                if (doneCyc0 == 0) begin
                    doneCyc0 = n;
                    r0[0] = int'(mis0); r0[1] = int'(bf0); r0[2] = int'(max0); r0[3] = int'(sum0);
                end
            end
            if (done2 === 1'b1) begin
                doneCnt2++;
                if (doneCyc2 == 0) begin
                    doneCyc2 = n;
                    r2[0] = int'(mis2); r2[1] = int'(bf2); r2[2] = int'(max2); r2[3] = int'(sum2);
                end
            end
            if (resetAt > 0 && n == resetAt + 1) begin
                rs[0] = int'(busy0); rs[1] = int'(pi0);  rs[2] = int'(mis0); rs[3] = int'(bf0);
                rs[4] = int'(max0);  rs[5] = int'(sum0); rs[6] = int'(busy2); rs[7] = int'(pi2) + int'(sum2);
            end
            if (n == startPulseAt) start = 1'b1;
            if (n == resetAt) rst = 1'b1;
        end
    endtask

    task automatic checkResults(input string tag, input int em, input int eb, input int ex, input int es);
        checkOutput({tag, " lat0 mismatch"}, r0[0], em);
        checkOutput({tag, " lat0 bitflip"},  r0[1], eb);
        checkOutput({tag, " lat0 max"},      r0[2], ex);
        checkOutput({tag, " lat0 sum"},      r0[3], es);
        checkOutput({tag, " lat2 mismatch"}, r2[0], em);
        checkOutput({tag, " lat2 bitflip"},  r2[1], eb);
        checkOutput({tag, " lat2 max"},      r2[2], ex);
        checkOutput({tag, " lat2 sum"},      r2[3], es);
    endtask

    task automatic checkTiming(input string tag);
        checkOutput({tag, " lat0 done cycle"}, doneCyc0, 129);
        checkOutput({tag, " lat2 done cycle"}, doneCyc2, 131);
        checkOutput({tag, " lat0 done pulses"}, doneCnt0, 1);
        checkOutput({tag, " lat2 done pulses"}, doneCnt2, 1);
    endtask

    initial begin
        int doneAt;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset pi",       int'(pi0),   0);
        checkOutput("reset busy",     int'(busy0), 0);
        checkOutput("reset done",     int'(done0), 0);
        checkOutput("reset mismatch", int'(mis0),  0);
        checkOutput("reset bitflip",  int'(bf0),   0);
        checkOutput("reset max",      int'(max0),  0);
        checkOutput("reset sum",      int'(sum0),  0);
        checkOutput("reset lat2 busy", int'(busy2) + int'(done2) + int'(pi2), 0);
        rst = 1'b0;

        applyStimulus(0, 0, 135);
        checkTiming("loopback");
        checkOutput("loopback lat0 busy window", busyErr0, 0);
        checkOutput("loopback lat2 busy window", busyErr2, 0);
        checkOutput("loopback first pi", piFirst0, 0);
        checkOutput("loopback last pi",  piLast0, 127);
        checkOutput("loopback lat2 pi held in drain", piHold2, 127);
        checkResults("loopback", 0, 0, 0, 0);

        mode = 2'd1;
        applyStimulus(0, 0, 135);
        checkTiming("xor1");
        checkResults("xor1", 128, 128, 1, 128);

        mode = 2'd2;
        applyStimulus(50, 0, 135);
        checkTiming("zero with mid-sweep start");
        checkResults("zero with mid-sweep start", 120, 256, 15, 960);

        applyStimulus(0, 60, 140);
        checkOutput("abort lat0 busy", rs[0], 0);
        checkOutput("abort lat0 pi",   rs[1], 0);
        checkOutput("abort lat0 mismatch", rs[2], 0);
        checkOutput("abort lat0 bitflip",  rs[3], 0);
        checkOutput("abort lat0 max",  rs[4], 0);
        checkOutput("abort lat0 sum",  rs[5], 0);
        checkOutput("abort lat2 busy", rs[6], 0);
        checkOutput("abort lat2 pi+sum", rs[7], 0);
        checkOutput("abort lat0 no done", doneCnt0, 0);
        checkOutput("abort lat2 no done", doneCnt2, 0);

        applyStimulus(0, 0, 135);
        checkTiming("restart");
        checkResults("restart", 120, 256, 15, 960);

        // The lat0 checker restarts in the cycle after its done; lat2 is still draining.
        applyStimulus(130, 0, 131);
        checkTiming("back-to-back first");
        checkResults("back-to-back first", 120, 256, 15, 960);
        doneAt = 0;
        for (int i = 0; i < 4; i++) r0[i] = -1;
        for (int m = 1; m <= 200; m++) begin
            @(negedge clk);
            if (done0 === 1'b1 && doneAt == 0) begin
                doneAt = m;
                r0[0] = int'(mis0); r0[1] = int'(bf0); r0[2] = int'(max0); r0[3] = int'(sum0);
            end
        end
        checkOutput("back-to-back second done cycle", doneAt, 128);
        checkOutput("back-to-back second mismatch", r0[0], 120);
        checkOutput("back-to-back second bitflip",  r0[1], 256);
        checkOutput("back-to-back second max",      r0[2], 15);
        checkOutput("back-to-back second sum",      r0[3], 960);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/partition_exhaustive_checker.md
Name: partition_exhaustive_checker

Overview:
- Sequential exhaustive-sweep checker for partitioned subcircuits.
- Drives every one of the 2^IN_W input patterns, in ascending order, into an exact and an approximate copy of the same partition.
- Compares the two outputs for each pattern and accumulates error metrics: mismatch count, total bit flips, maximum and summed absolute error.
- Replaces per-partition simulation testbenches with a synthesizable, parametrised block that tolerates pipelined DUTs.

Parameters:
- IN_W, 7: partition input width; sweep length is 2^IN_W patterns.
- OUT_W, 4: partition output width.
- DUT_LAT, 0: DUT latency in clock cycles from pi to exact_po/approx_po. 0 means combinational DUTs.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- pi  output  IN_W  pattern driven to both DUT copies.
- exact_po  input  OUT_W  exact DUT output.
- approx_po  input  OUT_W  approximate DUT output.
- busy  output  1  high while a sweep or drain is in progress.
- done  output  1  one-cycle pulse when results are final.
- mismatch_cnt  output  IN_W+1  number of patterns with exact_po != approx_po.
- bitflip_cnt  output  IN_W+$clog2(OUT_W+1)  sum of popcount(exact_po ^ approx_po).
- max_abs_err  output  OUT_W  maximum |exact_po - approx_po|, operands unsigned.
- sum_abs_err  output  IN_W+OUT_W  sum of |exact_po - approx_po|.

Behaviour:
- Reset: state=IDLE, pi=0, busy=0, done=0, all four accumulators=0. Reset overrides start and aborts any in-progress sweep; no done pulse is produced for an aborted sweep.
- FSM states: IDLE, SWEEP, DRAIN, FIN.
- IDLE, or FIN with start=1: clear accumulators, pi=0, go to SWEEP.
- SWEEP: pi increments by 1 each cycle. After pi=2^IN_W-1 has been presented for one cycle:
  - DUT_LAT>0: go to DRAIN, pi held at 2^IN_W-1.
  - DUT_LAT=0: go to FIN.
- DRAIN: stays exactly DUT_LAT cycles, then goes to FIN.
- FIN: done=1 for this one cycle only. Stays in FIN, results held, until start.
- busy=1 in SWEEP and DRAIN, 0 otherwise.
- start while busy=1 is ignored and has no side effects.
- Pattern tagging:
  - A DUT_LAT-deep valid shift register tags each presented pattern.
  - A comparison is accumulated on the clock edge where its tag emerges, i.e. sampling exact_po/approx_po DUT_LAT cycles after that pattern was on pi.
  - DUT_LAT=0: compare in the same cycle as pi.
  - Exactly 2^IN_W comparisons per sweep; none outside tagged cycles.
- Arithmetic:
  - abs error = exact_po>=approx_po ? exact_po-approx_po : approx_po-exact_po, computed at OUT_W width.
  - Accumulator widths are sized so they cannot overflow at worst case. No saturation logic is needed.
- Timing: start sampled high at edge k → pi=0 during cycle k+1. Last pattern is on pi during cycle k+2^IN_W. done is high during cycle k+2^IN_W+DUT_LAT+1.
- Outputs are registered. Accumulators update only on tagged cycles and are stable and readable from done onward until the next start.

Test Plan:
- Loopback (approx_po=exact_po=pi[3:0]), defaults, start at edge k → done exactly in cycle k+129, busy high for cycles k+1..k+128. mismatch=0, bitflip=0, max=0, sum=0.
- approx_po=exact_po^4'b0001, exact=pi[3:0] → mismatch=128, bitflip=128, max_abs_err=1, sum_abs_err=128.
- exact=pi[3:0], approx=0 → mismatch=120, bitflip=256, max_abs_err=15, sum_abs_err=960.
- DUT_LAT=2, with both DUT copies wrapped in two register stages, same functions as the previous scenario → identical counts; done in cycle k+131.
- Overlapping start and reset:
  - Pulse start at cycle k+50 during a sweep → ignored, results unchanged.
  - Assert rst at cycle k+60 → next cycle busy=0, pi=0, accumulators=0, no done.
  - Restart → normal 129-cycle sweep.
- Back-to-back: start in the cycle after done → accumulators cleared before reuse; second sweep yields identical results.
